// File: rtl/keypad_code_fifo.sv
// Keypad press detector feeding a first-word fall-through code queue.
// Each new press (or rolled-over key) pushes one code; a sticky flag records dropped presses.
module keypad_code_fifo #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned RELEASE_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               Code,
    input  logic                     Valid,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [3:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     key_held
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = $clog2(RELEASE_CYC + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   rel_cnt, rel_cnt_n;
    logic [3:0]      held_code, held_code_n;
    logic            push;

    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_n;
    logic            do_pop, push_eff, drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rel_cnt   <= '0;
            held_code <= '0;
        end else begin
            state     <= state_n;
            rel_cnt   <= rel_cnt_n;
            held_code <= held_code_n;
        end
    end

    always_comb begin
        state_n     = state;
        rel_cnt_n   = rel_cnt;
        held_code_n = held_code;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (Valid) begin
                    push        = 1'b1;
                    held_code_n = Code;
                    rel_cnt_n   = '0;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                if (Valid) begin
                    rel_cnt_n = '0;
                    if (Code != held_code) begin
                        push        = 1'b1;
                        held_code_n = Code;
                    end
                end else if (rel_cnt == RW'(RELEASE_CYC - 1)) begin
                    rel_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    rel_cnt_n = rel_cnt + RW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign key_held = (state == HOLD);

    // A pop frees the head slot on the same edge, so a full queue can still accept a push.
    assign do_pop   = rd_en && !empty;
    assign push_eff = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    always_comb begin
        count_n = count;
        if (push_eff && !do_pop)
            count_n = count + CW'(1);
        else if (!push_eff && do_pop)
            count_n = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_eff)
            mem[wr_ptr] <= Code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_eff)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            empty <= (count_n == '0);
            full  <= (count_n == CW'(DEPTH));
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/keypad_code_fifo.md
KEYPAD_CODE_FIFO -- requirements
Module: keypad_code_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of code entries stored (power of 2, minimum 2).
REQ-002 SHALL have parameter RELEASE_CYC, default 16, number of consecutive Valid-free clk cycles that ends a press.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Code  input  4  hex key code from the keypad scanner.
REQ-006 SHALL have port Valid  input  1  scanner strobe; Code is meaningful only while Valid=1.
REQ-007 SHALL have port rd_en  input  1  consumer pop request.
REQ-008 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 SHALL have port rd_data  output  4  head-of-queue code, first-word fall-through.
REQ-010 SHALL have port empty  output  1  queue holds 0 entries.
REQ-011 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: a press was dropped.
REQ-014 SHALL have port key_held  output  1  a press is in progress (FSM in HOLD).

Function
REQ-015 Press FSM SHALL have two states, IDLE and HOLD, plus a release counter of width ceil(log2(RELEASE_CYC+1)).
REQ-016 In IDLE, Valid=1 SHALL cause the FSM to generate one push of Code, latch Code as held_code, clear the release counter, and move to HOLD.
REQ-017 In HOLD, Valid=1 with Code==held_code SHALL clear the release counter and generate no push.
REQ-018 In HOLD, Valid=1 with Code!=held_code SHALL generate one push of the new Code, update held_code, clear the release counter, and stay in HOLD.
REQ-019 In HOLD, Valid=0 SHALL increment the release counter; when the counter reaches RELEASE_CYC-1 with Valid=0, the FSM SHALL return to IDLE on that edge.
REQ-020 key_held SHALL be 1 exactly while the FSM is in HOLD.
REQ-021 A push SHALL write Code into the queue on the same edge it is generated; the entry SHALL be visible on rd_data in the next cycle if the queue was empty.
REQ-022 rd_data SHALL equal the oldest stored entry whenever empty=0 and SHALL be 0 when empty=1.
REQ-023 rd_en=1 with empty=0 SHALL remove the head entry on the edge; rd_en=1 with empty=1 SHALL be ignored and SHALL leave every state unchanged.
REQ-024 A push with full=1 and no pop in the same cycle SHALL be dropped, SHALL leave the queue unchanged, and SHALL set overflow=1.
REQ-025 A push and a pop in the same cycle with full=1 SHALL both take effect; count SHALL stay DEPTH and overflow SHALL stay unchanged.
REQ-026 A push and a pop in the same cycle with 0<count<DEPTH SHALL both take effect and leave count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count, empty, and full SHALL be registered and consistent every cycle.
REQ-028 clr_ovf=1 SHALL clear overflow on the next edge; if a drop occurs in that same cycle, overflow SHALL end at 1.

Reset
REQ-029 reset=0 SHALL immediately and asynchronously force: FSM=IDLE, release counter=0, held_code=0, pointers=0, count=0, empty=1, full=0, overflow=0, rd_data=0, key_held=0.
REQ-030 While reset=0, Valid, rd_en, and clr_ovf SHALL be ignored.
REQ-031 Reset asserted during HOLD or with entries stored SHALL discard the press and all queued entries.
REQ-032 After reset deasserts, a Valid=1 already present SHALL be treated as a new press on the first rising edge.

Verification
REQ-033 Single press: Valid pulses with Code=4'hA every 5 cycles for 40 cycles, then stops -> exactly one entry 4'hA; key_held drops 16 cycles after the last pulse.
REQ-034 Re-press: Code=3 pressed, released for 16 cycles, then Code=3 pressed again -> two entries, 3 and 3.
REQ-035 Rolling key: during HOLD on 5, Valid arrives with Code=7 -> entries 5 then 7, and no return to IDLE in between.
REQ-036 Overflow: 9 distinct presses (codes 0..8) with no reads, DEPTH=8 -> full=1, count=8, overflow=1, and pops return 0..7; clr_ovf then clears overflow.
REQ-037 Simultaneous events: while full, a push and rd_en occur in the same cycle -> count stays 8, overflow stays 0, and the new code is the last entry popped; rd_en while empty -> no change.
REQ-038 Reset mid-operation: reset=0 asserted with count=3 during HOLD -> all outputs immediately at reset values; the next press after release is stored as the single entry.
